// File: rtl/nightrider_pkg.sv
// Shared constants for the Knight Rider scanner: mode encodings, scan direction
// and a constant-foldable ceil(log2) helper for sizing counters.
package nightrider_pkg;

    localparam logic [1:0] MODE_BOUNCE = 2'd0;
    localparam logic [1:0] MODE_WRAP   = 2'd1;
    localparam logic [1:0] MODE_TAIL   = 2'd2;
    localparam logic [1:0] MODE_OFF    = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: two-flop synchroniser, then a level that only follows the
// synced input after it has differed for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce
    import nightrider_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 160_000
) (
    input  logic clk_16mhz,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press_pulse
);

    localparam int CNT_W = clog2((DEBOUNCE_CYCLES > 2) ? DEBOUNCE_CYCLES : 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differ;

    assign w_differ = (r_sync2 != r_level);

    always_ff @(posedge clk_16mhz) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            // Any cycle where the synced input agrees with the level restarts the count.
            if (w_differ) begin
                if (r_cnt == CNT_LAST) begin
                    r_level <= r_sync2;
                    r_press <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level       = r_level;
    assign press_pulse = r_press;

endmodule

// File: rtl/nightrider_scanner.sv
// Parametrised Knight Rider scanner: a moving lit position over NUM_LEDS outputs
// with bounce, wrap, PWM-faded tail and off modes, cycled by the user button.
module nightrider_scanner
    import nightrider_pkg::*;
#(
    parameter int NUM_LEDS        = 8,
    parameter int STEP_CYCLES     = 1_600_000,
    parameter int TAIL_LEN        = 3,
    parameter int PWM_BITS        = 4,
    parameter int DEBOUNCE_CYCLES = 160_000
) (
    input  logic                clk_16mhz,
    input  logic                rst,
    input  logic                btn_usr,
    output logic [NUM_LEDS-1:0] led,
    output logic [1:0]          mode,
    output logic                step_tick
);

    localparam int POS_W  = clog2((NUM_LEDS > 2) ? NUM_LEDS : 2);
    localparam int STEP_W = clog2((STEP_CYCLES > 2) ? STEP_CYCLES : 2);
    localparam int HIST_N = (TAIL_LEN > 0) ? TAIL_LEN : 1;
    localparam logic [POS_W-1:0]    LAST_POS  = POS_W'(NUM_LEDS - 1);
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX   = '1;

    logic [1:0]          r_mode;
    logic [POS_W-1:0]    r_pos;
    logic                r_dir;
    logic [STEP_W-1:0]   r_step_cnt;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [POS_W-1:0]    r_hist [HIST_N];
    logic [HIST_N-1:0]   r_hist_vld;
    logic [NUM_LEDS-1:0] r_led;

    logic                w_level;
    logic                w_press_pulse;
    logic                w_press;
    logic                w_step;
    logic [POS_W-1:0]    w_next_pos;
    logic                w_next_dir;
    logic [NUM_LEDS-1:0] w_led_next;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk_16mhz  (clk_16mhz),
        .rst        (rst),
        .raw        (btn_usr),
        .level      (w_level),
        .press_pulse(w_press_pulse)
    );

    assign w_press = w_press_pulse & w_level;
    assign w_step  = (r_step_cnt == STEP_LAST);

    always_comb begin
        w_next_pos = r_pos;
        w_next_dir = r_dir;
        if (r_mode == MODE_WRAP) begin
            w_next_pos = (r_pos == LAST_POS) ? '0 : r_pos + POS_W'(1);
        end else if (NUM_LEDS > 1) begin
            // Reversal moves straight off the endpoint so it is never lit for two steps.
            if (r_dir == DIR_UP) begin
                if (r_pos == LAST_POS) begin
                    w_next_pos = r_pos - POS_W'(1);
                    w_next_dir = DIR_DOWN;
                end else begin
                    w_next_pos = r_pos + POS_W'(1);
                end
            end else begin
                if (r_pos == '0) begin
                    w_next_pos = POS_W'(1);
                    w_next_dir = DIR_UP;
                end else begin
                    w_next_pos = r_pos - POS_W'(1);
                end
            end
        end
    end

    // Head and tail contributions are OR-ed: the head is fully on and the dimmer
    // tail duty is a subset of the brighter one, so overlaps resolve naturally.
    always_comb begin
        w_led_next = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (r_mode != MODE_OFF && r_pos == POS_W'(i)) begin
                w_led_next[i] = 1'b1;
            end
            if (r_mode == MODE_TAIL) begin
                for (int k = 0; k < TAIL_LEN; k++) begin
                    if (r_hist_vld[k] && r_hist[k] == POS_W'(i) &&
                        r_pwm_cnt < (PWM_MAX >> (k + 1))) begin
                        w_led_next[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_16mhz) begin
        if (rst) begin
            r_mode     <= MODE_BOUNCE;
            r_pos      <= '0;
            r_dir      <= DIR_UP;
            r_step_cnt <= '0;
            r_pwm_cnt  <= '0;
            r_hist_vld <= '0;
            r_led      <= '0;
            for (int k = 0; k < HIST_N; k++) begin
                r_hist[k] <= '0;
            end
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
            r_led     <= w_led_next;
            if (w_press) begin
                r_mode     <= r_mode + 2'd1;
                r_pos      <= '0;
                r_dir      <= DIR_UP;
                r_step_cnt <= '0;
                r_hist_vld <= '0;
                for (int k = 0; k < HIST_N; k++) begin
                    r_hist[k] <= '0;
                end
            end else begin
                r_step_cnt <= w_step ? '0 : r_step_cnt + STEP_W'(1);
                if (w_step) begin
                    r_pos         <= w_next_pos;
                    r_dir         <= w_next_dir;
                    r_hist[0]     <= r_pos;
                    r_hist_vld[0] <= 1'b1;
                    for (int k = 1; k < HIST_N; k++) begin
                        r_hist[k]     <= r_hist[k-1];
                        r_hist_vld[k] <= r_hist_vld[k-1];
                    end
                end
            end
        end
    end

    assign led       = r_led;
    assign mode      = r_mode;
    assign step_tick = w_step & ~rst;

endmodule

// File: tb/tb_nightrider_scanner.sv
// Directed bench for nightrider_scanner with small parameters: scan sequences per
// mode, debounce latency, bounce rejection, press/step collision and mid-scan reset.
module tb_nightrider_scanner;

    logic       clk_16mhz;
    logic       rst;
    logic       btn_usr;
    logic [3:0] led;
    logic [1:0] mode;
    logic       step_tick;

    int total;
    int bad;
    int cyc;

    typedef struct {
        int         kind;      // 0 clean press, 1 bouncing press, 2 press landing on a step
        logic [1:0] exp_mode;
        int         nsteps;
        logic [1:0] pos [8];   // hand-derived head position after each step
    } vec_t;

    vec_t tbl [4];

    nightrider_scanner #(
        .NUM_LEDS       (4),
        .STEP_CYCLES    (4),
        .TAIL_LEN       (2),
        .PWM_BITS       (4),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk_16mhz(clk_16mhz),
        .rst      (rst),
        .btn_usr  (btn_usr),
        .led      (led),
        .mode     (mode),
        .step_tick(step_tick)
    );

    initial clk_16mhz = 1'b0;
    always #5 clk_16mhz = ~clk_16mhz;

    task automatic next_cycle();
        @(negedge clk_16mhz);
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    function automatic logic [3:0] oh(input logic [1:0] p);
        logic [3:0] one;
        one = 4'b0001;
        return one << p;
    endfunction

    // Walk nsteps scan steps from a freshly zeroed position/step counter.
    task automatic scan_check(input int idx, input int nsteps);
        int         s;
        int         ph;
        logic [3:0] exp_led;
        for (int j = 1; j <= nsteps * 4; j++) begin
            next_cycle();
            s  = (j - 1) / 4;
            ph = (cyc - 1) % 16;
            case (tbl[idx].exp_mode)
                2'd0, 2'd1: exp_led = oh(tbl[idx].pos[s]);
                2'd2: begin
                    exp_led = oh(tbl[idx].pos[s]);
                    if (s >= 1 && ph < 7) exp_led = exp_led | oh(tbl[idx].pos[s-1]);
                    if (s >= 2 && ph < 3) exp_led = exp_led | oh(tbl[idx].pos[s-2]);
                end
                default: exp_led = 4'b0000;
            endcase
            chk("scan_led", 32'(led), 32'(exp_led));
            chk("scan_mode", 32'(mode), 32'(tbl[idx].exp_mode));
            chk("scan_tick", 32'(step_tick), (j % 4 == 3) ? 32'd1 : 32'd0);
            if (j == 9) btn_usr = 1'b0;
        end
    endtask

    task automatic do_press(input int kind, input logic [1:0] new_mode);
        logic [1:0] old_mode;
        old_mode = new_mode - 2'd1;
        if (kind == 1) begin
            for (int i = 0; i < 30; i++) begin
                btn_usr = ((i / 3) % 2 == 0);
                next_cycle();
                chk("bounce_hold_mode", 32'(mode), 32'(old_mode));
            end
        end else if (kind == 2) begin
            next_cycle();
        end
        btn_usr = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            next_cycle();
            if (kind == 2 && k == 10) chk("coincide_tick", 32'(step_tick), 32'd1);
            chk("press_mode", 32'(mode), (k == 11) ? 32'(new_mode) : 32'(old_mode));
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        cyc     = 0;
        rst     = 1'b1;
        btn_usr = 1'b0;

        tbl[0].kind = 0; tbl[0].exp_mode = 2'd1; tbl[0].nsteps = 6;
        tbl[0].pos  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        tbl[1].kind = 1; tbl[1].exp_mode = 2'd2; tbl[1].nsteps = 6;
        tbl[1].pos  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1};
        tbl[2].kind = 2; tbl[2].exp_mode = 2'd3; tbl[2].nsteps = 6;
        tbl[2].pos  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        tbl[3].kind = 0; tbl[3].exp_mode = 2'd0; tbl[3].nsteps = 4;
        tbl[3].pos  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1};

        // Reset values, then a full bounce sweep in mode 0.
        next_cycle();
        next_cycle();
        chk("reset_led", 32'(led), 32'd0);
        chk("reset_mode", 32'(mode), 32'd0);
        chk("reset_tick", 32'(step_tick), 32'd0);
        rst = 1'b0;
        cyc = 0;
        scan_check(3, 8);

        // Modes 1, 2, 3, 0 via clean, bouncing, step-colliding and clean presses.
        for (int v = 0; v < 4; v++) begin
            do_press(tbl[v].kind, tbl[v].exp_mode);
            scan_check(v, tbl[v].nsteps);
        end

        // Now at pos=2 heading down: reset mid-scan.
        rst = 1'b1;
        next_cycle();
        chk("midreset_led", 32'(led), 32'd0);
        chk("midreset_mode", 32'(mode), 32'd0);
        chk("midreset_tick", 32'(step_tick), 32'd0);
        rst = 1'b0;
        cyc = 0;
        scan_check(3, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
